// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the multi-domain reset sequencer.
package reset_seq_pkg;

    // Sequencer state, also exported as the debug/CSR seq_state field.
    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StStretch = 2'd1,
        StRelease = 2'd2,
        StRun     = 2'd3
    } seq_state_e;

    // Counter width able to hold the larger of the stretch and step terminal counts.
    function automatic int unsigned cnt_width(input int unsigned stretch_cycles,
                                              input int unsigned step_cycles);
        int unsigned m;
        m = (stretch_cycles > step_cycles) ? stretch_cycles : step_cycles;
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset synchroniser: asserts asynchronously, de-asserts after STAGES clock edges.
module reset_sync_chain #(
    parameter int unsigned STAGES = 3
) (
    input  logic clock,
    input  logic reset_n_in,
    output logic sync_n
);

    logic [STAGES-1:0] chain;

    // Shift a constant 1 through the chain; any reset_n_in low clears every stage.
    always_ff @(posedge clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_n = chain[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Multi-domain reset sequencer: synchronised release, stretch period, then
// channel-by-channel release with a fixed gap; supports warm reset and scan override.
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned STRETCH_CYCLES = 8,
    parameter int unsigned STEP_CYCLES    = 4
) (
    input  logic              clock,
    input  logic              reset_n_in,
    input  logic              safeshift,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] reset_n_out,
    output logic              rst_done,
    output logic [1:0]        seq_state
);

    localparam int unsigned CNT_W = cnt_width(STRETCH_CYCLES, STEP_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_CH + 1);

    // With no stretch, a warm reset still passes through STRETCH for exactly one edge.
    localparam logic [CNT_W-1:0] STRETCH_LAST =
        (STRETCH_CYCLES == 0) ? '0 : CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

    logic              sync_n;
    seq_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  ch_idx;
    logic [NUM_CH-1:0] reset_n_int;
    logic              done_q;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock      (clock),
        .reset_n_in (reset_n_in),
        .sync_n     (sync_n)
    );

    // Sequencer FSM with registered channel resets and done flag.
    always_ff @(posedge clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state       <= StAssert;
            cnt         <= '0;
            ch_idx      <= '0;
            reset_n_int <= '0;
            done_q      <= 1'b0;
        end else begin
            unique case (state)
                StAssert: begin
                    if (sync_n) begin
                        cnt <= '0;
                        if (STRETCH_CYCLES == 0) begin
                            // Behaves as the stretch exit edge: release channel 0 now.
                            reset_n_int[0] <= 1'b1;
                            ch_idx         <= IDX_W'(1);
                            if (NUM_CH == 1) begin
                                state  <= StRun;
                                done_q <= 1'b1;
                            end else begin
                                state <= StRelease;
                            end
                        end else begin
                            state <= StStretch;
                        end
                    end
                end
                StStretch: begin
                    if (cnt == STRETCH_LAST) begin
                        cnt            <= '0;
                        reset_n_int[0] <= 1'b1;
                        ch_idx         <= IDX_W'(1);
                        if (NUM_CH == 1) begin
                            state  <= StRun;
                            done_q <= 1'b1;
                        end else begin
                            state <= StRelease;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StRelease: begin
                    if (cnt == STEP_LAST) begin
                        cnt <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_idx == IDX_W'(i)) begin
                                reset_n_int[i] <= 1'b1;
                            end
                        end
                        ch_idx <= ch_idx + 1'b1;
                        if (ch_idx == LAST_IDX) begin
                            state  <= StRun;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StRun: begin
                    // Warm reset skips the synchroniser and restarts from STRETCH.
                    if (sw_rst_req) begin
                        state       <= StStretch;
                        cnt         <= '0;
                        ch_idx      <= '0;
                        reset_n_int <= '0;
                        done_q      <= 1'b0;
                    end
                end
                default: state <= StAssert;
            endcase
        end
    end

    assign reset_n_out = reset_n_int | {NUM_CH{safeshift}};
    assign rst_done    = done_q;
    assign seq_state   = state;

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
- Parametrised multi-domain reset sequencer; next generation of the single-output reset synchroniser.
- Asserts all NUM_CH domain resets asynchronously and de-asserts them synchronously.
- After synchronisation, holds a programmable stretch period, then releases domains one at a time in index order with a fixed gap.
- Also supports a software-requested warm reset and a scan `safeshift` override. Sits at each NoC/DSU clock-domain root, feeding per-block resets.

Parameters:
- NUM_CH, 4, number of reset domains released in order 0..NUM_CH-1 (≥1)
- SYNC_STAGES, 3, flops in the de-assertion synchroniser chain (≥2)
- STRETCH_CYCLES, 8, cycles held in STRETCH after sync release (0 = skip STRETCH)
- STEP_CYCLES, 4, cycles between successive channel releases (≥1)

Ports:
- clock, input, 1, block clock
- reset_n_in, input, 1, asynchronous active-low reset; all state and outputs clear on its falling edge
- safeshift, input, 1, scan override; when 1, forces every reset_n_out bit to 1 combinationally
- sw_rst_req, input, 1, software warm-reset request, sampled synchronously; honoured only in RUN
- reset_n_out, output, NUM_CH, active-low per-domain resets
- rst_done, output, 1, 1 when all domains are released (state RUN)
- seq_state, output, 2, current FSM state for debug/CSR

Behaviour:
- Reset: reset_local = reset_n_in drives every flop's async clear. During reset: reset_n_out = 0 (unless safeshift), rst_done = 0, seq_state = ASSERT, counters = 0.
- Synchroniser: SYNC_STAGES-deep chain clocked by clock, D of first flop = 1, all flops cleared by reset_n_in. Output sync_n goes high on edge SYNC_STAGES after reset_n_in rises.
- States, encoded in seq_state: ASSERT=0, STRETCH=1, RELEASE=2, RUN=3.
- ASSERT: all channels held at 0. When sync_n = 1, the next edge moves to STRETCH, or to RELEASE if STRETCH_CYCLES = 0.
- STRETCH: cnt increments each cycle. On the edge where cnt reaches STRETCH_CYCLES-1: go to RELEASE, set reset_n_out[0] = 1, clear cnt, set ch_idx = 1.
- RELEASE: cnt counts 0..STEP_CYCLES-1. On wrap, set reset_n_out[ch_idx] = 1 and increment ch_idx.
- On the edge that releases channel NUM_CH-1: go to RUN and set rst_done = 1 on the same edge.
- NUM_CH = 1: the STRETCH exit edge enters RUN directly.
- RUN: holds. If sw_rst_req = 1 is sampled, the next edge synchronously drives all reset_n_out to 0, sets rst_done = 0, clears counters and enters STRETCH (synchroniser is not re-run).
- sw_rst_req outside RUN is ignored. It is not latched; the requester holds it until rst_done falls.
- Timing, first channel: channel 0 release edge = SYNC_STAGES + 1 + STRETCH_CYCLES edges after reset_n_in rises.
- Timing, channel k: released STEP_CYCLES·k edges after channel 0.
- reset_n_in falling mid-sequence (any state): immediate async clear of everything, including already-released channels. The sequence restarts fully.
- reset_n_in glitch shorter than one cycle: still clears everything; sequence restarts.
- safeshift: reset_n_out = reset_n_int | {NUM_CH{safeshift}}. The FSM and rst_done are unaffected. Deasserting safeshift restores internal values with no state change.
- Counter widths: cnt is $clog2(max(STRETCH_CYCLES, STEP_CYCLES, 2)) bits; ch_idx is $clog2(NUM_CH+1) bits. No wrap beyond terminal values.
- Once released, a channel stays released until reset_n_in falls or a warm reset is accepted.

Decomposition:
- Shared package reset_seq_pkg: seq_state_e enum (ASSERT/STRETCH/RELEASE/RUN, 2 bits) and a localparam function for counter width.
- One sub-module, reset_sync_chain: parametrised SYNC_STAGES flop chain with async active-low clear. It generalises sync_dff and is reusable elsewhere.

Test Plan (NUM_CH=4, SYNC_STAGES=3, STRETCH_CYCLES=8, STEP_CYCLES=4 unless stated):
- Power-on: reset_n_in rises at edge 0 -> reset_n_out goes 0001 at edge 12, 0011 at 16, 0111 at 20, 1111 at 24; rst_done=1 at 24; seq_state 0→1 at edge 4, 2 at 12, 3 at 24.
- Mid-sequence reset: drop reset_n_in at edge 18 (0011 released) -> reset_n_out = 0000, rst_done = 0, seq_state = 0 immediately without a clock edge; re-release repeats the power-on timing.
- Warm reset: sw_rst_req = 1 for one cycle in RUN at edge 30 -> edge 31 reset_n_out = 0000, rst_done = 0, STRETCH; channel 0 released at edge 39, all released with rst_done at 51.
- Ignored request: sw_rst_req held 1 during STRETCH and released before edge 24 -> no effect; power-on timing unchanged.
- safeshift: assert during ASSERT -> reset_n_out = 1111, seq_state still 0. Deassert at edge 14 -> reset_n_out = 0001.
- Edge parameters: STRETCH_CYCLES=0, NUM_CH=1 -> reset_n_out[0] and rst_done rise at edge SYNC_STAGES+1 = 4.
